watch_time_set_ctrl: RTL and testbench

- Sequences manual time-setting of the watch datapath.
- On entering edit mode it freezes the watch and snapshots the current time into a shadow register.
- While editing, it lets the user select the hour, min or sec field and step it up or down with wrap-around.
- On leaving edit mode it writes the shadow back to the watch datapath with a one-cycle load strobe. It also produces a blink enable so the FND can flash the selected field.

---
 rtl/watch_time_set_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_watch_time_set_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_time_set_ctrl.sv
// watch_time_set_ctrl: sequences manual time setting of the watch datapath.
// Freezes the watch, snapshots the live time into a shadow register, lets the
// user step hour/min/sec with wrap-around, then writes the shadow back with a
// single-cycle load strobe. Also generates the blink enable for the FND.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | watch running, waiting for a rising edge on i_edit
// S_CAPTURE   | one cycle: shadow <= live time with msec cleared
// S_EDIT_HOUR | hour field selected, up/down adjust hour
// S_EDIT_MIN  | minute field selected
// S_EDIT_SEC  | second field selected
// S_COMMIT    | one cycle: o_load strobes the shadow into the watch
module watch_time_set_ctrl #(
   parameter int unsigned CLK_HZ   = 100_000_000,
   parameter int unsigned BLINK_HZ = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_edit,
   input  logic        i_btn_next,
   input  logic        i_btn_up,
   input  logic        i_btn_down,
   input  logic [23:0] i_time,
   output logic        o_run,
   output logic        o_load,
   output logic [23:0] o_load_time,
   output logic [1:0]  o_field_sel,
   output logic        o_blink
);

   // Cycles between blink toggles; clamped so tiny clock settings still work.
   localparam int unsigned BLINK_HALF =
      (CLK_HZ / (2 * BLINK_HZ) > 0) ? CLK_HZ / (2 * BLINK_HZ) : 1;
   localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(BLINK_HALF - 1);

   localparam logic [5:0] HOUR_MAX = 6'd23;
   localparam logic [5:0] MS_MAX   = 6'd59;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_EDIT_HOUR,
      S_EDIT_MIN,
      S_EDIT_SEC,
      S_COMMIT
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             r_edit_d;
   logic [4:0]       r_hour;
   logic [5:0]       r_min;
   logic [5:0]       r_sec;
   logic             r_run;
   logic             r_load;
   logic [1:0]       r_field_sel;
   logic             r_blink;
   logic [CNT_W-1:0] r_blink_cnt;

   logic       w_in_edit;
   logic       w_next_in_edit;
   logic       w_btn_live;
   logic       w_up;
   logic       w_dn;
   logic       w_btn_any;
   logic [4:0] w_hour_step;
   logic [5:0] w_min_step;
   logic [5:0] w_sec_step;
   logic       w_unused;

   // Field code presented on o_field_sel for a given state.
   function automatic logic [1:0] field_of(input state_t s);
      logic [1:0] f;
      case (s)
         S_EDIT_HOUR: f = 2'd3;
         S_EDIT_MIN:  f = 2'd2;
         S_EDIT_SEC:  f = 2'd1;
         default:     f = 2'd0;
      endcase
      return f;
   endfunction

   // One step up or down with wrap. Out-of-range captured values snap into
   // range: up wraps to 0, down lands on the maximum.
   function automatic logic [5:0] step_wrap(input logic [5:0] v,
                                            input logic [5:0] v_max,
                                            input logic       up);
      logic [5:0] r;
      if (up) r = (v >= v_max) ? 6'd0 : v + 6'd1;
      else    r = ((v == 6'd0) || (v > v_max)) ? v_max : v - 6'd1;
      return r;
   endfunction

   assign w_in_edit      = (field_of(r_state) != 2'd0);
   assign w_next_in_edit = (field_of(w_next_state) != 2'd0);

   // Buttons only count while editing and not leaving edit mode this cycle.
   assign w_btn_live = w_in_edit & i_edit;
   assign w_up       = w_btn_live & i_btn_up & ~i_btn_down;
   assign w_dn       = w_btn_live & i_btn_down & ~i_btn_up;
   assign w_btn_any  = w_btn_live & (i_btn_next | i_btn_up | i_btn_down);

   assign w_hour_step = 5'(step_wrap({1'b0, r_hour}, HOUR_MAX, w_up));
   assign w_min_step  = step_wrap(r_min, MS_MAX, w_up);
   assign w_sec_step  = step_wrap(r_sec, MS_MAX, w_up);

   // msec of the live time is never captured; the shadow always holds 0 there.
   assign w_unused = &{1'b0, i_time[6:0]};

   // State register and i_edit history for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_edit_d <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_edit_d <= i_edit;
      end
   end

   // Next-state logic; dropping i_edit wins over any button in edit states.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:      if (i_edit && !r_edit_d) w_next_state = S_CAPTURE;
         S_CAPTURE:   w_next_state = S_EDIT_HOUR;
         S_EDIT_HOUR: begin
            if (!i_edit)         w_next_state = S_COMMIT;
            else if (i_btn_next) w_next_state = S_EDIT_MIN;
         end
         S_EDIT_MIN:  begin
            if (!i_edit)         w_next_state = S_COMMIT;
            else if (i_btn_next) w_next_state = S_EDIT_SEC;
         end
         S_EDIT_SEC:  begin
            if (!i_edit)         w_next_state = S_COMMIT;
            else if (i_btn_next) w_next_state = S_EDIT_HOUR;
         end
         S_COMMIT:    w_next_state = S_IDLE;
         default:     w_next_state = S_IDLE;
      endcase
   end

   // Registered control outputs, decoded from the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_run       <= 1'b1;
         r_load      <= 1'b0;
         r_field_sel <= 2'd0;
      end else begin
         r_run       <= (w_next_state == S_IDLE);
         r_load      <= (w_next_state == S_COMMIT);
         r_field_sel <= field_of(w_next_state);
      end
   end

   // Shadow time: snapshot in CAPTURE, then per-field adjustment while editing.
   // The adjustment uses the field selected before a simultaneous next press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hour <= 5'd0;
         r_min  <= 6'd0;
         r_sec  <= 6'd0;
      end else if (r_state == S_CAPTURE) begin
         r_hour <= i_time[23:19];
         r_min  <= i_time[18:13];
         r_sec  <= i_time[12:7];
      end else if (w_up || w_dn) begin
         case (r_state)
            S_EDIT_HOUR: r_hour <= w_hour_step;
            S_EDIT_MIN:  r_min  <= w_min_step;
            S_EDIT_SEC:  r_sec  <= w_sec_step;
            default:     ;
         endcase
      end
   end

   // Blink timer: runs only while staying in an edit state; any button or a
   // fresh entry restarts it with the field shown.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b1;
      end else if (!w_next_in_edit || !w_in_edit || w_btn_any) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b1;
      end else if (r_blink_cnt == CNT_TC) begin
         r_blink_cnt <= '0;
         r_blink     <= ~r_blink;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   assign o_run       = r_run;
   assign o_load      = r_load;
   assign o_load_time = {r_hour, r_min, r_sec, 7'd0};
   assign o_field_sel = r_field_sel;
   assign o_blink     = r_blink;

endmodule

// File: tb/tb_watch_time_set_ctrl.sv
// Testbench for watch_time_set_ctrl: directed scenarios plus randomized
// stimulus compared against a cycle-level behavioural model.
module tb_watch_time_set_ctrl;

   localparam int CLK_HZ   = 100;
   localparam int BLINK_HZ = 2;
   localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_edit = 1'b0;
   logic        i_btn_next = 1'b0;
   logic        i_btn_up = 1'b0;
   logic        i_btn_down = 1'b0;
   logic [23:0] i_time = '0;
   logic        o_run;
   logic        o_load;
   logic [23:0] o_load_time;
   logic [1:0]  o_field_sel;
   logic        o_blink;

   int n_checks = 0;
   int n_fail   = 0;

   watch_time_set_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_edit      (i_edit),
      .i_btn_next  (i_btn_next),
      .i_btn_up    (i_btn_up),
      .i_btn_down  (i_btn_down),
      .i_time      (i_time),
      .o_run       (o_run),
      .o_load      (o_load),
      .o_load_time (o_load_time),
      .o_field_sel (o_field_sel),
      .o_blink     (o_blink)
   );

   always #5 clk = ~clk;

   // Behavioural model: mode 0 running, 1 snapshot, 2 editing, 3 write-back.
   // Fields kept as plain integers; m_sel uses the output code (3 h, 2 m, 1 s).
   int   m_mode = 0;
   int   m_h = 0, m_m = 0, m_s = 0;
   int   m_sel = 3;
   int   m_since = 0;
   int   m_d = 0;
   logic m_prev = 1'b0;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
         m_sel = 3; m_since = 0; m_prev = 1'b0;
      end else begin
         case (m_mode)
            0: if (i_edit && !m_prev) m_mode = 1;
            1: begin
               m_h = int'(i_time[23:19]);
               m_m = int'(i_time[18:13]);
               m_s = int'(i_time[12:7]);
               m_mode = 2; m_sel = 3; m_since = 0;
            end
            2: begin
               if (!i_edit) m_mode = 3;
               else begin
                  if (i_btn_up || i_btn_down || i_btn_next) m_since = 0;
                  else m_since++;
                  if (i_btn_up != i_btn_down) begin
                     m_d = i_btn_up ? 1 : -1;
                     if (m_sel == 3)      m_h = (m_h + m_d + 24) % 24;
                     else if (m_sel == 2) m_m = (m_m + m_d + 60) % 60;
                     else                 m_s = (m_s + m_d + 60) % 60;
                  end
                  if (i_btn_next) m_sel = (m_sel == 1) ? 3 : m_sel - 1;
               end
            end
            default: m_mode = 0;
         endcase
         m_prev = i_edit;
      end
   end

   function automatic logic        exp_run();   return m_mode == 0; endfunction
   function automatic logic        exp_load();  return m_mode == 3; endfunction
   function automatic logic [1:0]  exp_sel();   return (m_mode == 2) ? 2'(m_sel) : 2'd0; endfunction
   function automatic logic        exp_blink(); return (m_mode != 2) || ((m_since / HALF) % 2 == 0); endfunction
   function automatic logic [23:0] exp_time();  return {5'(m_h), 6'(m_m), 6'(m_s), 7'd0}; endfunction

   function automatic logic [23:0] rand_time();
      return {5'($urandom_range(0, 23)), 6'($urandom_range(0, 59)),
              6'($urandom_range(0, 59)), 7'($urandom_range(0, 99))};
   endfunction

   task automatic go_idle();
      i_edit = 1'b0; i_btn_next = 1'b0; i_btn_up = 1'b0; i_btn_down = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic enter_edit(input logic [23:0] t);
      i_time = t;
      i_edit = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic press(input logic up, input logic dn, input logic nx);
      i_btn_up = up; i_btn_down = dn; i_btn_next = nx;
      @(negedge clk);
      i_btn_up = 1'b0; i_btn_down = 1'b0; i_btn_next = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (o_run !== 1'b1) begin n_fail++; $display("FAIL rst_run: got %0b want 1", o_run); end
      n_checks++; if (o_load !== 1'b0) begin n_fail++; $display("FAIL rst_load: got %0b want 0", o_load); end
      n_checks++; if (o_field_sel !== 2'd0) begin n_fail++; $display("FAIL rst_sel: got %0d want 0", o_field_sel); end
      n_checks++; if (o_blink !== 1'b1) begin n_fail++; $display("FAIL rst_blink: got %0b want 1", o_blink); end
      n_checks++; if (o_load_time !== 24'd0) begin n_fail++; $display("FAIL rst_time: got %h want 0", o_load_time); end
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (o_run !== 1'b1 || o_field_sel !== 2'd0) begin
         n_fail++; $display("FAIL post_rst_idle: got run=%0b sel=%0d want run=1 sel=0", o_run, o_field_sel); end
   endtask

   task automatic test_capture();
      i_time = {5'd12, 6'd34, 6'd56, 7'd78};
      i_edit = 1'b1;
      @(negedge clk);
      n_checks++; if (o_run !== 1'b0) begin n_fail++; $display("FAIL cap_run_fall: got %0b want 0", o_run); end
      @(negedge clk);
      n_checks++; if (o_run !== 1'b0) begin n_fail++; $display("FAIL cap_run: got %0b want 0", o_run); end
      n_checks++; if (o_field_sel !== 2'd3) begin n_fail++; $display("FAIL cap_sel: got %0d want 3", o_field_sel); end
      n_checks++; if (o_load_time !== {5'd12, 6'd34, 6'd56, 7'd0}) begin
         n_fail++; $display("FAIL cap_time: got %h want %h", o_load_time, {5'd12, 6'd34, 6'd56, 7'd0}); end
      n_checks++; if (o_blink !== 1'b1) begin n_fail++; $display("FAIL cap_blink: got %0b want 1", o_blink); end
   endtask

   task automatic test_wrap();
      go_idle();
      enter_edit({5'd23, 6'd17, 6'd0, 7'd5});
      press(1'b1, 1'b0, 1'b0);
      n_checks++; if (o_load_time[23:19] !== 5'd0) begin n_fail++; $display("FAIL hour_wrap_up: got %0d want 0", o_load_time[23:19]); end
      press(1'b0, 1'b0, 1'b1);
      press(1'b0, 1'b0, 1'b1);
      n_checks++; if (o_field_sel !== 2'd1) begin n_fail++; $display("FAIL sel_sec: got %0d want 1", o_field_sel); end
      press(1'b0, 1'b1, 1'b0);
      n_checks++; if (o_load_time[12:7] !== 6'd59) begin n_fail++; $display("FAIL sec_wrap_down: got %0d want 59", o_load_time[12:7]); end
      n_checks++; if (o_load_time[18:13] !== 6'd17) begin n_fail++; $display("FAIL min_untouched: got %0d want 17", o_load_time[18:13]); end
      n_checks++; if (o_load_time[6:0] !== 7'd0 || o_load_time[23:19] !== 5'd0) begin
         n_fail++; $display("FAIL wrap_other_fields: got %h want hour=0 msec=0", o_load_time); end
   endtask

   task automatic test_commit();
      int         loads;
      int         at;
      logic [23:0] ltime;
      logic       run_seen [8];
      go_idle();
      enter_edit({5'd10, 6'd0, 6'd0, 7'd0});
      press(1'b0, 1'b0, 1'b1);
      repeat (3) press(1'b1, 1'b0, 1'b0);
      i_edit = 1'b0;
      loads = 0; at = -1; ltime = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         run_seen[i] = o_run;
         if (o_load === 1'b1) begin loads++; ltime = o_load_time; at = i; end
      end
      n_checks++; if (loads !== 1) begin n_fail++; $display("FAIL commit_pulses: got %0d want 1", loads); end
      n_checks++; if (ltime !== {5'd10, 6'd3, 6'd0, 7'd0}) begin
         n_fail++; $display("FAIL commit_time: got %h want %h", ltime, {5'd10, 6'd3, 6'd0, 7'd0}); end
      n_checks++; if (at < 0 || at >= 7 || run_seen[at] !== 1'b0 || run_seen[at+1] !== 1'b1) begin
         n_fail++; $display("FAIL commit_run_after: load at cycle %0d, run not 0 then 1", at); end
   endtask

   task automatic test_up_down_same();
      go_idle();
      enter_edit({5'd1, 6'd30, 6'd0, 7'd0});
      press(1'b0, 1'b0, 1'b1);
      press(1'b1, 1'b1, 1'b0);
      n_checks++; if (o_load_time[18:13] !== 6'd30) begin n_fail++; $display("FAIL up_down_same: got min=%0d want 30", o_load_time[18:13]); end
      n_checks++; if (o_field_sel !== 2'd2) begin n_fail++; $display("FAIL up_down_sel: got %0d want 2", o_field_sel); end
   endtask

   task automatic test_up_next();
      go_idle();
      enter_edit({5'd5, 6'd0, 6'd0, 7'd0});
      press(1'b1, 1'b0, 1'b1);
      n_checks++; if (o_load_time[23:19] !== 5'd6) begin n_fail++; $display("FAIL up_next_hour: got %0d want 6", o_load_time[23:19]); end
      n_checks++; if (o_field_sel !== 2'd2) begin n_fail++; $display("FAIL up_next_sel: got %0d want 2", o_field_sel); end
   endtask

   task automatic test_reset_mid_edit();
      logic [23:0] t;
      int          loads;
      go_idle();
      t = rand_time();
      enter_edit(t);
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      n_checks++; if (o_load_time[23:19] !== 5'((int'(t[23:19]) + 2) % 24)) begin
         n_fail++; $display("FAIL mid_edit_hour: got %0d want %0d", o_load_time[23:19], (int'(t[23:19]) + 2) % 24); end
      #2;
      reset = 1'b1;
      i_edit = 1'b0;
      #1;
      n_checks++; if (o_run !== 1'b1 || o_field_sel !== 2'd0 || o_load !== 1'b0) begin
         n_fail++; $display("FAIL async_rst: got run=%0b sel=%0d load=%0b want 1 0 0", o_run, o_field_sel, o_load); end
      @(negedge clk);
      reset = 1'b0;
      loads = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (o_load === 1'b1) loads++;
      end
      n_checks++; if (loads !== 0) begin n_fail++; $display("FAIL rst_no_load: got %0d pulses want 0", loads); end
      n_checks++; if (o_run !== 1'b1 || o_field_sel !== 2'd0) begin
         n_fail++; $display("FAIL rst_idle: got run=%0b sel=%0d want 1 0", o_run, o_field_sel); end
      n_checks++; if (o_load_time !== 24'd0) begin n_fail++; $display("FAIL rst_shadow: got %h want 0", o_load_time); end
   endtask

   task automatic test_blink();
      go_idle();
      enter_edit({5'd3, 6'd20, 6'd10, 7'd0});
      press(1'b0, 1'b0, 1'b1);
      n_checks++; if (o_blink !== 1'b1 || o_field_sel !== 2'd2) begin
         n_fail++; $display("FAIL blink_start: got blink=%0b sel=%0d want 1 2", o_blink, o_field_sel); end
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         n_checks++; if (o_blink !== logic'((k / HALF) % 2 == 0)) begin
            n_fail++; $display("FAIL blink_run k=%0d: got %0b want %0b", k, o_blink, (k / HALF) % 2 == 0); end
      end
      press(1'b1, 1'b0, 1'b0);
      n_checks++; if (o_blink !== 1'b1 || o_load_time[18:13] !== 6'd21) begin
         n_fail++; $display("FAIL blink_restart: got blink=%0b min=%0d want 1 21", o_blink, o_load_time[18:13]); end
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         n_checks++; if (o_blink !== logic'((k / HALF) % 2 == 0)) begin
            n_fail++; $display("FAIL blink_rerun k=%0d: got %0b want %0b", k, o_blink, (k / HALF) % 2 == 0); end
      end
   endtask

   task automatic test_random();
      go_idle();
      for (int n = 0; n < 800; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 19) == 0) i_edit = ~i_edit;
         i_btn_up   = ($urandom_range(0, 3) == 0);
         i_btn_down = ($urandom_range(0, 3) == 0);
         i_btn_next = ($urandom_range(0, 4) == 0);
         i_time     = rand_time();
         @(negedge clk);
         n_checks++; if (o_run !== exp_run()) begin n_fail++; $display("FAIL rnd_run n=%0d: got %0b want %0b", n, o_run, exp_run()); end
         n_checks++; if (o_load !== exp_load()) begin n_fail++; $display("FAIL rnd_load n=%0d: got %0b want %0b", n, o_load, exp_load()); end
         n_checks++; if (o_field_sel !== exp_sel()) begin n_fail++; $display("FAIL rnd_sel n=%0d: got %0d want %0d", n, o_field_sel, exp_sel()); end
         n_checks++; if (o_blink !== exp_blink()) begin n_fail++; $display("FAIL rnd_blink n=%0d: got %0b want %0b", n, o_blink, exp_blink()); end
         n_checks++; if (o_load_time !== exp_time()) begin n_fail++; $display("FAIL rnd_time n=%0d: got %h want %h", n, o_load_time, exp_time()); end
      end
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_capture();
      test_wrap();
      test_commit();
      test_up_down_same();
      test_up_next();
      test_reset_mid_edit();
      test_blink();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
